// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK 2-D correlation over a DIMxDIM raster pixel stream.
// Transposed-form systolic array (K rows of K MACs), rows chained through
// DIM-K entry row-delay lines. Rounded, arithmetic-shifted, saturated output.
// Optional feature macro: CONV2D_RELU_EN (negative results forced to zero).
module conv2d_stream #(
  parameter int DIM   = 32,
  parameter int K     = 5,
  parameter int PW    = 9,
  parameter int WW    = 16,
  parameter int AW    = PW + WW + 2*$clog2(K),
  parameter int SHIFT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pxl_valid,
  input  logic [PW-1:0]          pxl_in,
  input  logic                   wt_we,
  input  logic [$clog2(K*K)-1:0] wt_addr,
  input  logic [WW-1:0]          wt_data,
  output logic [PW-1:0]          conv_out,
  output logic                   out_valid,
  output logic                   frame_done
);
  localparam int NT = K*K;
  localparam int CW = $clog2(DIM);
  localparam int DL = DIM - K;

  localparam logic signed [AW:0] MAXV = (AW+1)'(2**(PW-1) - 1);
  localparam logic signed [AW:0] MINV = ~MAXV;

  logic signed [WW-1:0] r_w [NT];
  logic signed [AW-1:0] w_acc [K][K];
  logic signed [AW-1:0] w_rin [K];
  logic signed [AW-1:0] w_px;

  logic [CW-1:0] r_row, r_col;
  logic          w_win, w_last;
  logic          r_win_p, r_last_p;

  logic signed [AW:0] w_ext, w_rnd, w_shr;
  logic [PW-1:0]      w_res;

  assign w_px = {{(AW-PW){pxl_in[PW-1]}}, pxl_in};

  // weight table: runtime writable, out-of-range addresses dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NT; i++) r_w[i] <= '0;
    end else if (wt_we && (32'(wt_addr) < 32'(NT))) begin
      r_w[wt_addr] <= wt_data;
    end
  end

  // MAC array: chain runs from column K-1 down to column 0 so the oldest pixel
  // of a row meets weight[r*K+0], giving correlation (non-flipped) order
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_mac
      localparam int TAP = r*K + (K-1-j);
      logic signed [AW-1:0] w_wt, w_prod, w_prev;
      logic signed [AW-1:0] r_acc;

      assign w_wt   = {{(AW-WW){r_w[TAP][WW-1]}}, r_w[TAP]};
      assign w_prod = w_px * w_wt;

      if (j == K-1) begin : g_head
        assign w_prev = w_rin[r];
      end else begin : g_body
        assign w_prev = w_acc[r][j+1];
      end

      // accumulate only on accepted pixels; bubbles freeze the array
      always_ff @(posedge clk) begin
        if (reset)          r_acc <= '0;
        else if (pxl_valid) r_acc <= w_prev + w_prod;
      end

      assign w_acc[r][j] = r_acc;
    end
  end

  assign w_rin[0] = '0;

  // row links: previous row's partial sum delayed to line up one image row later
  for (genvar r = 1; r < K; r++) begin : g_link
    if (DL == 0) begin : g_direct
      assign w_rin[r] = w_acc[r-1][0];
    end else begin : g_dly
      logic signed [AW-1:0] r_dly [DL];

      // row-delay shift register, advanced with the pixel stream
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DL; i++) r_dly[i] <= '0;
        end else if (pxl_valid) begin
          r_dly[0] <= w_acc[r-1][0];
          for (int i = 1; i < DL; i++) r_dly[i] <= r_dly[i-1];
        end
      end

      assign w_rin[r] = r_dly[DL-1];
    end
  end

  // window is complete when the accepted pixel is past the first K-1 rows/cols;
  // this also masks stale sums from the previous row or frame
  assign w_win  = pxl_valid && (r_row >= CW'(K-1)) && (r_col >= CW'(K-1));
  assign w_last = pxl_valid && (r_row == CW'(DIM-1)) && (r_col == CW'(DIM-1));

  // raster position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (pxl_valid) begin
      if (r_col == CW'(DIM-1)) begin
        r_col <= '0;
        r_row <= (r_row == CW'(DIM-1)) ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // window flags for the pixel just accepted; cleared on any non-accepting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_p  <= 1'b0;
      r_last_p <= 1'b0;
    end else begin
      r_win_p  <= w_win;
      r_last_p <= w_last;
    end
  end

  // one extra bit keeps the rounding bias from wrapping the accumulator
  assign w_ext = {w_acc[K-1][0][AW-1], w_acc[K-1][0]};

  if (SHIFT > 0) begin : g_rnd
    localparam logic signed [AW:0] RND = (AW+1)'(1) << (SHIFT-1);
    assign w_rnd = w_ext + RND;
  end else begin : g_nornd
    assign w_rnd = w_ext;
  end

  assign w_shr = w_rnd >>> SHIFT;

  // saturate to the signed pixel range, then optional rectification
  always_comb begin
    w_res = w_shr[PW-1:0];
    if (w_shr > MAXV)      w_res = MAXV[PW-1:0];
    else if (w_shr < MINV) w_res = MINV[PW-1:0];
`ifdef CONV2D_RELU_EN
    if (w_shr[AW]) w_res = '0;
`else
`endif
  end

  // output register: free-running strobe, data held between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_out   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= r_win_p;
      frame_done <= r_last_p;
      if (r_win_p) conv_out <= w_res;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: two DUTs (SHIFT=0 and SHIFT=4) fed the same stream.
// A window-sum reference model pushes expected results with their due cycle;
// a negedge monitor pops and compares whenever the DUTs strobe out_valid.
module tb_conv2d_stream;
  localparam int DIM  = 8;
  localparam int K    = 3;
  localparam int PW   = 9;
  localparam int WW   = 16;
  localparam int NT   = K*K;
  localparam int WA   = $clog2(NT);
  localparam int NPIX = DIM*DIM;
  localparam int NWIN = (DIM-K+1)*(DIM-K+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pxl_valid = 1'b0;
  logic [PW-1:0] pxl_in = '0;
  logic          wt_we = 1'b0;
  logic [WA-1:0] wt_addr = '0;
  logic [WW-1:0] wt_data = '0;
  logic [PW-1:0] co0, co1;
  logic          ov0, ov1, fd0, fd1;

  always #5 clk = ~clk;

  conv2d_stream #(.DIM(DIM), .K(K), .PW(PW), .WW(WW), .SHIFT(0)) u_s0 (
    .clk(clk), .reset(reset), .pxl_valid(pxl_valid), .pxl_in(pxl_in),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .conv_out(co0), .out_valid(ov0), .frame_done(fd0));

  conv2d_stream #(.DIM(DIM), .K(K), .PW(PW), .WW(WW), .SHIFT(4)) u_s4 (
    .clk(clk), .reset(reset), .pxl_valid(pxl_valid), .pxl_in(pxl_in),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .conv_out(co1), .out_valid(ov1), .frame_done(fd1));

  typedef struct { longint s; bit last; int due; } exp_t;
  exp_t   q[$];
  exp_t   me;

  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     w_m [NT];
  int     row_m = 0;
  int     col_m = 0;
  longint acc_m [DIM][DIM];
  int     seen0[$];
  int     seen1[$];
  int     refq[$];
  int     frm [2*NPIX];
  int     fd_cnt = 0;
  int     last0 = 0;
  int     last1 = 0;
  int     rst_due = -1;
  bit     mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int sx(input logic [PW-1:0] v);
    return int'($signed(v));
  endfunction

  // round half up, floor-divide by 2^sh, clamp to the signed pixel range
  function automatic int scale(input longint s, input int sh);
    longint v, d, qt;
    v = s;
    if (sh > 0) begin
      d  = longint'(1) << sh;
      v  = s + d / 2;
      qt = v / d;
      if ((v % d != 0) && (v < 0)) qt = qt - 1;
      v  = qt;
    end
    if (v > (2**(PW-1) - 1)) v = 2**(PW-1) - 1;
    if (v < -(2**(PW-1)))    v = -(2**(PW-1));
`ifdef CONV2D_RELU_EN
    if (v < 0) v = 0;
`else
`endif
    return int'(v);
  endfunction

  // each accepted pixel adds its product to every window it belongs to,
  // using the weight in force at acceptance
  task automatic model_pix(input int p);
    exp_t e;
    int ey, ex;
    if (row_m == 0 && col_m == 0)
      for (int y = 0; y < DIM; y++)
        for (int x = 0; x < DIM; x++) acc_m[y][x] = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        ey = row_m + (K-1-r);
        ex = col_m + (K-1-c);
        if (ey < DIM && ex < DIM)
          acc_m[ey][ex] += longint'(p) * longint'(w_m[r*K+c]);
      end
    if (row_m >= K-1 && col_m >= K-1) begin
      e.s    = acc_m[row_m][col_m];
      e.last = (row_m == DIM-1) && (col_m == DIM-1);
      e.due  = cyc + 2;
      q.push_back(e);
    end
    col_m++;
    if (col_m == DIM) begin
      col_m = 0;
      row_m++;
      if (row_m == DIM) row_m = 0;
    end
  endtask

  task automatic step(input bit v, input int p, input bit we, input int a, input int d);
    @(posedge clk);
    #1;
    pxl_valid = v;
    pxl_in    = p[PW-1:0];
    wt_we     = we;
    wt_addr   = a[WA-1:0];
    wt_data   = d[WW-1:0];
    if (v) model_pix(p);
    if (we && a >= 0 && a < NT) w_m[a] = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic set_w(input int a, input int d);
    step(1'b0, 0, 1'b1, a, d);
  endtask

  task automatic stream(input int n, input int duty, input int wr_at, input int wa, input int wd);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      if (duty < 100)
        while (int'($urandom_range(99)) >= duty && k < 20) begin
          idle(1);
          k++;
        end
      step(1'b1, frm[i], i == wr_at, wa, wd);
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 2*NPIX; i++) frm[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 2*NPIX; i++) frm[i] = int'($urandom_range(511)) - 256;
  endtask

  task automatic rand_weights();
    for (int a = 0; a < NT; a++) set_w(a, int'($urandom_range(16)) - 8);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    pxl_valid = 1'b0;
    wt_we     = 1'b1;
    wt_addr   = WA'(4);
    wt_data   = WW'(77);
    rst_due   = cyc + 1;
    for (int a = 0; a < NT; a++) w_m[a] = 0;
    row_m = 0;
    col_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wt_we = 1'b0;
  endtask

  function automatic int lastv(input int which);
    if (which == 0) return (seen0.size() > 0) ? seen0[seen0.size()-1] : -9999;
    return (seen1.size() > 0) ? seen1[seen1.size()-1] : -9999;
  endfunction

  // monitor: compare each strobe against the scoreboard head and its due cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == rst_due) begin
        last0 = 0;
        last1 = 0;
      end
      if (q.size() > 0 && q[0].due < cyc) begin
        check("missed_strobe", 0, 1);
        void'(q.pop_front());
      end
      if (ov0 || ov1) begin
        if (q.size() == 0 || q[0].due != cyc) begin
          check("unexpected_strobe", int'(ov0) + int'(ov1), 0);
        end else begin
          me    = q.pop_front();
          last0 = scale(me.s, 0);
          last1 = scale(me.s, 4);
          check("out_valid_pair", int'(ov0) + int'(ov1), 2);
          check("conv_out_s0", sx(co0), last0);
          check("conv_out_s4", sx(co1), last1);
          check("frame_done", int'(fd0) + int'(fd1), me.last ? 2 : 0);
          seen0.push_back(sx(co0));
          seen1.push_back(sx(co1));
          if (fd0) fd_cnt++;
        end
      end else begin
        check("idle_frame_done", int'(fd0) + int'(fd1), 0);
        check("hold_s0", sx(co0), last0);
        check("hold_s4", sx(co1), last1);
      end
    end
  end

  initial begin
    int nz;
    for (int a = 0; a < NT; a++) w_m[a] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(ov0) + int'(ov1), 0);
    check("rst_frame_done", int'(fd0) + int'(fd1), 0);
    check("rst_conv_out_s0", sx(co0), 0);
    check("rst_conv_out_s4", sx(co1), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // centre tap only, raster-index pixels; out-of-range write ignored
    set_w(4, 1);
    set_w(12, 500);
    for (int i = 0; i < 2*NPIX; i++) frm[i] = i % NPIX;
    seen0.delete(); seen1.delete(); fd_cnt = 0;
    stream(NPIX, 100, -1, 0, 0);
    idle(3);
    check("A_count", seen0.size(), NWIN);
    check("A_first", (seen0.size() > 0) ? seen0[0] : -9999, 9);
    check("A_last", lastv(0), 54);
    check("A_frame_done_cnt", fd_cnt, 1);

    // box filter, then saturation, then negative weights
    for (int a = 0; a < NT; a++) set_w(a, 1);
    fill_const(2);
    seen0.delete(); seen1.delete();
    stream(NPIX, 100, -1, 0, 0);
    idle(3);
    check("B_count", seen0.size(), NWIN);
    check("B_sum18", lastv(0), 18);
    fill_const(100);
    stream(NPIX, 100, -1, 0, 0);
    idle(3);
    check("B_sat", lastv(0), 255);
    for (int a = 0; a < NT; a++) set_w(a, -1);
    fill_const(2);
    stream(NPIX, 100, -1, 0, 0);
    idle(3);
`ifdef CONV2D_RELU_EN
    check("B_neg", lastv(0), 0);
`else
    check("B_neg", lastv(0), -18);
`endif

    // fixed-point rounding on the SHIFT=4 instance
    for (int a = 0; a < NT; a++) set_w(a, 0);
    set_w(4, 24);
    fill_const(3);
    seen0.delete(); seen1.delete();
    stream(NPIX, 100, -1, 0, 0);
    idle(3);
    check("C_round_pos", lastv(1), 5);
    check("C_raw_pos", lastv(0), 72);
    fill_const(-3);
    stream(NPIX, 100, -1, 0, 0);
    idle(3);
`ifdef CONV2D_RELU_EN
    check("C_round_neg", lastv(1), 0);
`else
    check("C_round_neg", lastv(1), -4);
`endif

    // random frames: gap-free run, then 30% duty with identical pixels
    rand_weights();
    fill_rand();
    seen0.delete(); seen1.delete();
    stream(2*NPIX, 100, -1, 0, 0);
    idle(3);
    refq = seen0;
    seen0.delete(); seen1.delete();
    stream(2*NPIX, 30, -1, 0, 0);
    idle(3);
    check("D_count", seen0.size(), refq.size());
    for (int i = 0; i < refq.size() && i < seen0.size(); i++)
      check("D_seq", seen0[i], refq[i]);

    // reset after 20 pixels; weights must read as zero afterwards
    fill_rand();
    stream(20, 100, -1, 0, 0);
    idle(2);
    do_reset();
    seen0.delete(); seen1.delete();
    stream(NPIX, 100, -1, 0, 0);
    idle(3);
    nz = 0;
    foreach (seen0[i]) if (seen0[i] != 0) nz++;
    check("E_count", seen0.size(), NWIN);
    check("E_zero_weights", nz, 0);
    rand_weights();
    fill_rand();
    seen0.delete();
    stream(NPIX, 100, -1, 0, 0);
    idle(3);
    check("E_clean_count", seen0.size(), NWIN);

    // weight[0] rewrites between frames and coincident with pixel 40
    rand_weights();
    set_w(0, 1);
    fill_rand();
    stream(NPIX, 100, -1, 0, 0);
    set_w(0, 2);
    stream(NPIX, 100, -1, 0, 0);
    set_w(0, 1);
    stream(NPIX, 100, 40, 0, 2);
    idle(4);

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation time limit");
  end

endmodule
